// File: rtl/mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// Sits between the MEM pipeline stage and an external asynchronous 16-bit
// SRAM. A LD or ST request from the MEM stage is turned into a strobe
// sequence that lasts WAIT_CYCLES clocks. It is followed by a single DONE
// cycle in which the pipeline is released. mem_ready goes to the hazard
// detector and freezes the whole pipeline while an access is outstanding.
//
// Parameters
//   ADDR_W       SRAM word-address width
//   WAIT_CYCLES  SRAM access cycles per transfer (1..15)
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   mem_rd_en    MEM stage executes LD
//   mem_wr_en    MEM stage executes ST (wins over mem_rd_en)
//   mem_addr     word address from the ALU
//   mem_wdata    store data
//   mem_rdata    registered load data, held until the next completed read
//   mem_ready    1 = pipeline may advance, 0 = stall (combinational)
//   sram_addr    registered SRAM address
//   sram_wdata   registered SRAM write data
//   sram_rdata   SRAM read data
//   sram_ce_n    chip enable, active-low
//   sram_oe_n    output enable, active-low
//   sram_we_n    write enable, active-low
//   access_cnt   completed-transfer counter, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [15:0]       access_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The counter holds the number of ACCESS cycles remaining after the current one.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] wait_cnt_reg;
  logic       is_wr_reg;
  logic       req;
  logic       ready_fsm;
  logic       param_ok;

  assign req      = mem_rd_en | mem_wr_en;
  assign param_ok = (WAIT_CYCLES >= 1) && (WAIT_CYCLES <= 15);

  // This block is evaluated once at time 0, so an illegal WAIT_CYCLES is flagged immediately.
  always_comb begin
    assert (param_ok)
      else $error("mem_stage_sram_ctrl: WAIT_CYCLES=%0d outside 1..15", WAIT_CYCLES);
  end

  // Next-state logic and ready decode.
  always_comb begin
    state_next = state_reg;
    ready_fsm  = 1'b1;
    case (state_reg)
      IDLE: begin
        // Drop ready in the same cycle the request appears, so the pipeline freezes at once.
        ready_fsm = !req;
        if (req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        ready_fsm = 1'b0;
        if (wait_cnt_reg == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        ready_fsm  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        ready_fsm  = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // While reset is held, the pipeline is never stalled.
  assign mem_ready = rst ? 1'b1 : ready_fsm;

  // State register and the datapath that goes with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      is_wr_reg    <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= 16'h0000;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      mem_rdata    <= 16'h0000;
      access_cnt   <= 16'h0000;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req) begin
            // Address, data and direction are frozen here for the whole transfer.
            sram_addr    <= mem_addr;
            sram_wdata   <= mem_wdata;
            is_wr_reg    <= mem_wr_en;
            sram_ce_n    <= 1'b0;
            sram_we_n    <= !mem_wr_en;
            sram_oe_n    <= mem_wr_en;
            wait_cnt_reg <= WAIT_LOAD;
          end
        end
        ACCESS: begin
          if (wait_cnt_reg != 4'd0) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end else begin
            // Last access cycle: the SRAM output is still enabled, so sample it before releasing the strobes.
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (!is_wr_reg) begin
              mem_rdata <= sram_rdata;
            end
          end
        end
        DONE: begin
          if (access_cnt != 16'hFFFF) begin
            access_cnt <= access_cnt + 16'd1;
          end
        end
        default: begin
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
//
// Directed bench for mem_stage_sram_ctrl. Instance "a" uses WAIT_CYCLES=2 and
// instance "b" uses WAIT_CYCLES=1, which covers back-to-back ST/LD.
// Each instance has a small asynchronous SRAM model behind it.
// Inputs are driven on the falling edge. Outputs are checked 1 ns later,
// away from the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic mdl_init;

  // ---------------- instance a: WAIT_CYCLES = 2 ----------------
  logic        a_rst, a_rd_en, a_wr_en, a_ready;
  logic [15:0] a_addr, a_wdata, a_rdata, a_sram_addr, a_sram_wdata, a_sram_rdata, a_cnt;
  logic        a_ce_n, a_oe_n, a_we_n;
  logic [15:0] mem_a [0:255];

  mem_stage_sram_ctrl #(.ADDR_W(16), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(a_rst), .mem_rd_en(a_rd_en), .mem_wr_en(a_wr_en),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ready(a_ready),
    .sram_addr(a_sram_addr), .sram_wdata(a_sram_wdata), .sram_rdata(a_sram_rdata),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n), .access_cnt(a_cnt)
  );

  assign a_sram_rdata = (!a_ce_n && !a_oe_n) ? mem_a[a_sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (mdl_init) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 16'h0000;
      mem_a[8'h40] <= 16'hBEEF;
    end else if (!a_ce_n && !a_we_n) begin
      mem_a[a_sram_addr[7:0]] <= a_sram_wdata;
    end
  end

  // ---------------- instance b: WAIT_CYCLES = 1 ----------------
  logic        b_rst, b_rd_en, b_wr_en, b_ready;
  logic [15:0] b_addr, b_wdata, b_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata, b_cnt;
  logic        b_ce_n, b_oe_n, b_we_n;
  logic [15:0] mem_b [0:255];

  mem_stage_sram_ctrl #(.ADDR_W(16), .WAIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(b_rst), .mem_rd_en(b_rd_en), .mem_wr_en(b_wr_en),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(b_ready),
    .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .access_cnt(b_cnt)
  );

  assign b_sram_rdata = (!b_ce_n && !b_oe_n) ? mem_b[b_sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (mdl_init) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 16'h0000;
    end else if (!b_ce_n && !b_we_n) begin
      mem_b[b_sram_addr[7:0]] <= b_sram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Advance to the next falling edge. The caller drives inputs, then calls settle().
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    mdl_init = 1'b1;
    a_rst = 1'b1; a_rd_en = 1'b1; a_wr_en = 1'b0; a_addr = 16'h0000; a_wdata = 16'h0000;
    b_rst = 1'b1; b_rd_en = 1'b1; b_wr_en = 1'b0; b_addr = 16'h0000; b_wdata = 16'h0000;

    // ---- Reset held 3 cycles with a pending read ----
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk("rst_ready", a_ready, 1);
      $display("reset cycle %0d ready=%0b", i, a_ready);
    end
    chk("rst_ce_n", a_ce_n, 1);
    chk("rst_oe_n", a_oe_n, 1);
    chk("rst_we_n", a_we_n, 1);
    chk("rst_rdata", a_rdata, 16'h0000);
    chk("rst_cnt", a_cnt, 16'h0000);
    chk("rst_b_ready", b_ready, 1);

    // ---- Read 0x0040, WAIT_CYCLES=2 ----
    step(); mdl_init = 1'b0; a_rst = 1'b0; a_rd_en = 1'b1; a_addr = 16'h0040;
    b_rst = 1'b0; b_rd_en = 1'b0; settle();
    chk("rd_ready_n0", a_ready, 0);
    step(); settle();
    chk("rd_ready_n1", a_ready, 0);
    chk("rd_ce_n1", a_ce_n, 0);
    chk("rd_oe_n1", a_oe_n, 0);
    chk("rd_we_n1", a_we_n, 1);
    chk("rd_addr", a_sram_addr, 16'h0040);
    step(); settle();
    chk("rd_ready_n2", a_ready, 0);
    chk("rd_oe_n2", a_oe_n, 0);
    step(); settle();
    chk("rd_ready_done", a_ready, 1);
    chk("rd_oe_done", a_oe_n, 1);
    chk("rd_ce_done", a_ce_n, 1);
    chk("rd_rdata", a_rdata, 16'hBEEF);
    a_rd_en = 1'b0;
    step(); settle();
    chk("rd_idle_ready", a_ready, 1);
    chk("rd_cnt", a_cnt, 16'd1);
    $display("read 0x0040 -> rdata=0x%04h cnt=%0d", a_rdata, a_cnt);

    // ---- Write 0x1234 to 0x0012, inputs change during the stall ----
    step(); a_wr_en = 1'b1; a_addr = 16'h0012; a_wdata = 16'h1234; settle();
    chk("wr_ready_n0", a_ready, 0);
    step(); a_addr = 16'h0099; a_wdata = 16'hFFFF; settle();
    chk("wr_ready_n1", a_ready, 0);
    chk("wr_we_n1", a_we_n, 0);
    chk("wr_oe_n1", a_oe_n, 1);
    chk("wr_addr_n1", a_sram_addr, 16'h0012);
    chk("wr_wdata_n1", a_sram_wdata, 16'h1234);
    step(); settle();
    chk("wr_ready_n2", a_ready, 0);
    chk("wr_we_n2", a_we_n, 0);
    chk("wr_addr_n2", a_sram_addr, 16'h0012);
    chk("wr_wdata_n2", a_sram_wdata, 16'h1234);
    step(); settle();
    chk("wr_ready_done", a_ready, 1);
    chk("wr_we_done", a_we_n, 1);
    chk("wr_rdata_kept", a_rdata, 16'hBEEF);
    a_wr_en = 1'b0;
    step(); settle();
    chk("wr_cnt", a_cnt, 16'd2);
    chk("wr_mem", mem_a[8'h12], 16'h1234);
    $display("write 0x0012 <- 0x%04h cnt=%0d", mem_a[8'h12], a_cnt);

    // ---- Simultaneous rd+wr: a write only ----
    step(); a_rd_en = 1'b1; a_wr_en = 1'b1; a_addr = 16'h0020; a_wdata = 16'h5555; settle();
    chk("both_ready_n0", a_ready, 0);
    step(); settle();
    chk("both_we_n1", a_we_n, 0);
    chk("both_oe_n1", a_oe_n, 1);
    step(); settle();
    chk("both_we_n2", a_we_n, 0);
    chk("both_oe_n2", a_oe_n, 1);
    step(); settle();
    chk("both_ready_done", a_ready, 1);
    a_rd_en = 1'b0; a_wr_en = 1'b0;
    step(); settle();
    chk("both_cnt", a_cnt, 16'd3);
    chk("both_mem", mem_a[8'h20], 16'h5555);
    chk("both_rdata_kept", a_rdata, 16'hBEEF);
    $display("rd+wr 0x0020 <- 0x%04h cnt=%0d", mem_a[8'h20], a_cnt);

    // ---- Reset in the 2nd ACCESS cycle ----
    step(); a_rd_en = 1'b1; a_addr = 16'h0040; settle();
    chk("rr_ready_n0", a_ready, 0);
    step(); settle();
    chk("rr_oe_n1", a_oe_n, 0);
    step(); a_rst = 1'b1; settle();
    chk("rr_ready_in_rst", a_ready, 1);
    step(); a_rst = 1'b0; a_rd_en = 1'b0; settle();
    chk("rr_ce_n", a_ce_n, 1);
    chk("rr_oe_n", a_oe_n, 1);
    chk("rr_we_n", a_we_n, 1);
    chk("rr_ready_idle", a_ready, 1);
    chk("rr_cnt", a_cnt, 16'd0);
    chk("rr_rdata", a_rdata, 16'h0000);
    step(); settle();
    chk("rr_cnt_nodone", a_cnt, 16'd0);
    $display("reset mid-access -> cnt=%0d strobes=%0b%0b%0b", a_cnt, a_ce_n, a_oe_n, a_we_n);

    // Subsequent read of 0x0012 completes normally
    step(); a_rd_en = 1'b1; a_addr = 16'h0012; settle();
    chk("post_ready_n0", a_ready, 0);
    step(); settle();
    chk("post_ready_n1", a_ready, 0);
    step(); settle();
    chk("post_ready_n2", a_ready, 0);
    step(); settle();
    chk("post_ready_done", a_ready, 1);
    chk("post_rdata", a_rdata, 16'h1234);
    a_rd_en = 1'b0;
    step(); settle();
    chk("post_cnt", a_cnt, 16'd1);
    $display("read 0x0012 -> rdata=0x%04h cnt=%0d", a_rdata, a_cnt);

    // ---- Back-to-back ST then LD, WAIT_CYCLES=1 (instance b) ----
    step(); b_wr_en = 1'b1; b_addr = 16'h0030; b_wdata = 16'hA5A5; settle();
    chk("b2b_st_ready_n0", b_ready, 0);
    step(); settle();
    chk("b2b_st_ready_n1", b_ready, 0);
    chk("b2b_st_we_n1", b_we_n, 0);
    step(); settle();
    chk("b2b_st_done", b_ready, 1);
    chk("b2b_st_we_done", b_we_n, 1);
    b_wr_en = 1'b0; b_rd_en = 1'b1; b_addr = 16'h0030; b_wdata = 16'h0000;
    step(); settle();
    chk("b2b_ld_ready_n0", b_ready, 0);
    chk("b2b_cnt1", b_cnt, 16'd1);
    step(); settle();
    chk("b2b_ld_ready_n1", b_ready, 0);
    chk("b2b_ld_oe_n1", b_oe_n, 0);
    step(); settle();
    chk("b2b_ld_done", b_ready, 1);
    chk("b2b_ld_rdata", b_rdata, 16'hA5A5);
    b_rd_en = 1'b0;
    step(); settle();
    chk("b2b_cnt2", b_cnt, 16'd2);
    chk("b2b_idle_ready", b_ready, 1);
    $display("back-to-back ST/LD 0x0030 -> rdata=0x%04h cnt=%0d", b_rdata, b_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory-stage controller between the MEM pipeline stage and an external asynchronous 16-bit SRAM that has configurable wait states.
- Accepts LD/ST requests from the MEM stage and runs the SRAM strobe sequence.
- Produces mem_ready, which the hazard detector uses to freeze the whole pipeline until the access completes.
- Read data is returned registered, for the MEM/WB latch.

Parameters:
- ADDR_W, 16, SRAM word-address width.
- WAIT_CYCLES, 2, SRAM access cycles per transfer; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- mem_rd_en  in  1  MEM stage is executing LD
- mem_wr_en  in  1  MEM stage is executing ST
- mem_addr  in  ADDR_W  word address from ALU result
- mem_wdata  in  16  store data
- mem_rdata  out  16  load data, registered
- mem_ready  out  1  1 = no access pending or access finishing this cycle; 0 = stall pipeline
- sram_addr  out  ADDR_W  SRAM address, registered
- sram_wdata  out  16  SRAM write data, registered
- sram_rdata  in  16  SRAM read data
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low
- access_cnt  out  16  completed-transfer counter, saturating

Behaviour:
- Reset values:
  - state = IDLE.
  - sram_ce_n, sram_oe_n and sram_we_n = 1.
  - sram_addr, sram_wdata, mem_rdata and access_cnt = 0.
  - Wait counter = 0.
  - mem_ready = 1 while rst is high, regardless of request inputs.
- States: IDLE, ACCESS, DONE.
- Request: req = mem_rd_en | mem_wr_en. If both are high, the access is treated as a write; mem_rd_en is ignored.
- mem_ready is combinational:
  - IDLE: mem_ready = !req. This ensures the pipeline freezes in the same cycle the request appears.
  - ACCESS: mem_ready = 0.
  - DONE: mem_ready = 1.
- IDLE with req at a clock edge:
  - Latch mem_addr into sram_addr, mem_wdata into sram_wdata, and the write/read type.
  - Set ce_n = 0. Set we_n = 0 for a write, or oe_n = 0 for a read.
  - Load wait counter with WAIT_CYCLES-1 and go to ACCESS.
- ACCESS:
  - Strobes and address stay stable, and the inputs are not resampled.
  - When the counter is non-zero, decrement it and stay in ACCESS.
  - When the counter is zero, go to DONE and deassert all strobes to 1 at that edge.
  - On a read, also capture sram_rdata into mem_rdata at that same edge.
- DONE:
  - Lasts exactly one cycle with mem_ready = 1; the pipeline advances at the end of this cycle.
  - Increments access_cnt, saturating at 0xFFFF.
  - Unconditionally goes to IDLE. The still-held request is not re-issued.
- Latency: a request first seen in IDLE at cycle N gives mem_ready low for cycles N..N+WAIT_CYCLES, and mem_ready high in DONE at cycle N+WAIT_CYCLES+1. The total stall is WAIT_CYCLES+1 cycles.
- Back-to-back requests: the next request is seen in IDLE one cycle after DONE. There is no bubble-free chaining.
- mem_rdata holds its value until the next completed read; writes do not alter it.
- A request deasserted during ACCESS (for example by a flush) does not abort the transfer. The access completes and DONE still occurs.
- rst high in any state:
  - Return to IDLE at the next edge with all reset values.
  - A write in progress may be partially applied to SRAM; this is acceptable.
  - No DONE pulse is generated for it.
- WAIT_CYCLES outside 1..15 is illegal; a simulation assertion fires at time 0.

Test Plan:
- Reset: hold rst for 3 cycles with mem_rd_en = 1 -> mem_ready = 1, all strobes = 1, mem_rdata = 0, access_cnt = 0.
- Read, WAIT_CYCLES = 2: mem_rd_en = 1, addr = 0x0040, SRAM model returns 0xBEEF -> mem_ready low for exactly 3 cycles, oe_n low for 2 cycles, mem_rdata = 0xBEEF in DONE, access_cnt = 1.
- Write: mem_wr_en = 1, addr = 0x0012, wdata = 0x1234; change mem_addr and mem_wdata during the stall -> we_n low for 2 cycles, sram_addr stays 0x0012 and sram_wdata stays 0x1234 throughout, the model stores 0x1234 at 0x0012, mem_rdata is unchanged.
- Simultaneous: rd_en = wr_en = 1 -> write cycle only (we_n = 0, oe_n = 1 throughout).
- Back-to-back: ST then LD in consecutive pipeline slots with WAIT_CYCLES = 1 -> two 2-cycle stalls, each separated by one DONE cycle, access_cnt = 2, and the LD returns the just-stored value.
- Reset mid-access: assert rst in the 2nd ACCESS cycle -> strobes = 1 and state = IDLE on the next edge, no mem_ready pulse from DONE, access_cnt = 0; a subsequent read completes normally.
